// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   ID/EX operand pipeline register. Resolves forwarding and source selection
//   for ALU operands A and B plus store data, then registers them for the EX
//   stage. Supports stall hold, flush bubble insertion, a valid bit, a sticky
//   reserved-select error flag and a saturating bubble counter.
//
//   Optional feature macro: ALU_OPB_UIMM_EN
//     defined   : ALUSrcB=3 selects the U-immediate {imm, zeros}
//     undefined : ALUSrcB=3 is reserved, falls back to fwdB and flags sel_err
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   stall, flush        hold all registers / insert bubble (flush wins)
//   in_valid            decode presents a valid instruction
//   ForwardA, ForwardB  forward selects (0 regfile, 1 memwb, 2 exmem, 3 rsvd)
//   ALUSrcA             0 fwdA, 1 pc, 2 zero, 3 rsvd
//   ALUSrcB             0 fwdB, 1 sext(imm), 2 const 4, 3 U-imm or rsvd
//   rs1_data, rs2_data  register file read data
//   exmem_result        EX/MEM ALU result
//   memwb_result        MEM/WB writeback value
//   imm, pc             raw immediate, PC of decoding instruction
//   op_a, op_b          registered ALU operands
//   store_data          registered fwdB value
//   out_valid           registered valid for EX
//   sel_err             sticky reserved-select flag
//   bubble_cnt          saturating flush bubble count
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [XLEN-1:0]  memwb_result,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  store_data,
  output logic             out_valid,
  output logic             sel_err,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] imm_sext;
  logic            src_b_rsvd;
  logic            rsvd_seen;

  assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    fwd_a = rs1_data;
    case (ForwardA)
      2'd1:    fwd_a = memwb_result;
      2'd2:    fwd_a = exmem_result;
      default: fwd_a = rs1_data;
    endcase
  end

  always_comb begin
    fwd_b = rs2_data;
    case (ForwardB)
      2'd1:    fwd_b = memwb_result;
      2'd2:    fwd_b = exmem_result;
      default: fwd_b = rs2_data;
    endcase
  end

  always_comb begin
    src_a = fwd_a;
    case (ALUSrcA)
      2'd1:    src_a = pc;
      2'd2:    src_a = '0;
      default: src_a = fwd_a;
    endcase
  end

`ifdef ALU_OPB_UIMM_EN
  assign src_b_rsvd = 1'b0;
`else
  assign src_b_rsvd = (ALUSrcB == 2'd3);
`endif

  always_comb begin
    src_b = fwd_b;
    case (ALUSrcB)
      2'd1: src_b = imm_sext;
      2'd2: src_b = XLEN'(4);
`ifdef ALU_OPB_UIMM_EN
      2'd3: src_b = {imm, {(XLEN-IMM_W){1'b0}}};
`else
      2'd3: src_b = fwd_b;
`endif
      default: src_b = fwd_b;
    endcase
  end

  // Only a valid instruction can raise the error; bubbles carry junk selects.
  assign rsvd_seen = in_valid &&
                     ((ForwardA == 2'd3) || (ForwardB == 2'd3) ||
                      (ALUSrcA == 2'd3) || src_b_rsvd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
      out_valid  <= 1'b0;
      sel_err    <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
      out_valid  <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!stall) begin
      op_a       <= src_a;
      op_b       <= src_b;
      store_data <= fwd_b;
      out_valid  <= in_valid;
      if (rsvd_seen)
        sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid;
  logic [1:0]  ForwardA, ForwardB, ALUSrcA, ALUSrcB;
  logic [31:0] rs1_data, rs2_data, exmem_result, memwb_result, pc;
  logic [11:0] imm;
  logic [31:0] op_a, op_b, store_data;
  logic        out_valid, sel_err;
  logic [1:0]  bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        v;
    logic        e;
    logic [1:0]  c;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;

`ifdef ALU_OPB_UIMM_EN
  localparam bit UIMM = 1'b1;
`else
  localparam bit UIMM = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .IMM_W(12), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .exmem_result(exmem_result),
    .memwb_result(memwb_result), .imm(imm), .pc(pc),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .out_valid(out_valid),
    .sel_err(sel_err), .bubble_cnt(bubble_cnt)
  );

  // Reference model of one clock edge, computed from the currently driven inputs.
  function automatic exp_t model_next(exp_t cur);
    exp_t        n;
    logic [31:0] fa, fb, a, b, sx;
    logic        rsvd;
    n = cur;
    fa = (ForwardA == 2'd1) ? memwb_result : (ForwardA == 2'd2) ? exmem_result : rs1_data;
    fb = (ForwardB == 2'd1) ? memwb_result : (ForwardB == 2'd2) ? exmem_result : rs2_data;
    a  = (ALUSrcA == 2'd1) ? pc : (ALUSrcA == 2'd2) ? 32'd0 : fa;
    sx = 32'($signed(imm));
    if (ALUSrcB == 2'd1)      b = sx;
    else if (ALUSrcB == 2'd2) b = 32'd4;
    else if (ALUSrcB == 2'd3 && UIMM) b = {imm, 20'd0};
    else                      b = fb;
    rsvd = in_valid && (ForwardA == 2'd3 || ForwardB == 2'd3 || ALUSrcA == 2'd3 ||
                        (ALUSrcB == 2'd3 && !UIMM));
    if (flush) begin
      n.a = 0; n.b = 0; n.sd = 0; n.v = 0;
      n.c = (cur.c == 2'd3) ? 2'd3 : cur.c + 2'd1;
    end else if (!stall) begin
      n.a = a; n.b = b; n.sd = fb; n.v = in_valid;
      n.e = cur.e | rsvd;
    end
    return n;
  endfunction

  // Push the model's expectation, clock the DUT, then pop and compare.
  task automatic cycle(input string name);
    exp_t e;
    m = model_next(m);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if ({op_a, op_b, store_data, out_valid, sel_err, bubble_cnt} !== e) begin
      tests_failed++;
      $display("FAIL %s: got a=%h b=%h sd=%h v=%b e=%b c=%0d, want a=%h b=%h sd=%h v=%b e=%b c=%0d",
               name, op_a, op_b, store_data, out_valid, sel_err, bubble_cnt,
               e.a, e.b, e.sd, e.v, e.e, e.c);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0;
    ForwardA = 0; ForwardB = 0; ALUSrcA = 0; ALUSrcB = 0;
    rs1_data = 0; rs2_data = 0; exmem_result = 0; memwb_result = 0; imm = 0; pc = 0;
  endtask

  task automatic check_zero(input string name);
    tests_run++;
    if ({op_a, op_b, store_data, out_valid, sel_err, bubble_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL %s: got a=%h b=%h sd=%h v=%b e=%b c=%0d, want all zero",
               name, op_a, op_b, store_data, out_valid, sel_err, bubble_cnt);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    check_zero("reset_state");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    m = '0;
  endtask

  task automatic test_forward();
    in_valid = 1; ForwardB = 2'd2; exmem_result = 32'h1234; ALUSrcB = 2'd0;
    rs2_data = 32'hDEAD0000; memwb_result = 32'h5555;
    cycle("fwd_exmem");
    tests_run++;
    if (op_b !== 32'h1234 || store_data !== 32'h1234 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fwd_exmem_lit: got b=%h sd=%h v=%b, want 00001234 00001234 1",
               op_b, store_data, out_valid);
    end
    ForwardA = 2'd1; memwb_result = 32'h77; cycle("fwd_a_memwb");
    ForwardA = 2'd2; exmem_result = 32'h99; cycle("fwd_a_exmem");
    ForwardA = 2'd0; rs1_data = 32'hCAFE; cycle("fwd_a_reg");
    in_valid = 0; cycle("invalid_capture");
  endtask

  task automatic test_sext();
    in_valid = 1; ALUSrcB = 2'd1; imm = 12'hFFC; ForwardB = 2'd1; memwb_result = 32'd5;
    cycle("sext_neg");
    tests_run++;
    if (op_b !== 32'hFFFF_FFFC || store_data !== 32'd5) begin
      tests_failed++;
      $display("FAIL sext_neg_lit: got b=%h sd=%h, want fffffffc 00000005", op_b, store_data);
    end
    imm = 12'h7FF; cycle("sext_pos");
  endtask

  task automatic test_stall_flush();
    in_valid = 1; ALUSrcA = 2'd1; pc = 32'h100; ALUSrcB = 2'd2;
    cycle("pc_const4");
    tests_run++;
    if (op_a !== 32'h100 || op_b !== 32'd4) begin
      tests_failed++;
      $display("FAIL pc_const4_lit: got a=%h b=%h, want 00000100 00000004", op_a, op_b);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h200 + 32'(i); ALUSrcA = 2'(i); ALUSrcB = 2'd1; imm = 12'(i * 7);
      in_valid = i[0];
      cycle("stall_hold");
    end
    tests_run++;
    if (op_a !== 32'h100 || op_b !== 32'd4 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_hold_lit: got a=%h b=%h v=%b, want 00000100 00000004 1",
               op_a, op_b, out_valid);
    end
    flush = 1;
    cycle("stall_flush");
    tests_run++;
    if (out_valid !== 1'b0 || bubble_cnt !== 2'd1) begin
      tests_failed++;
      $display("FAIL stall_flush_lit: got v=%b c=%0d, want 0 1", out_valid, bubble_cnt);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_bubble_sat();
    logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    flush = 1; in_valid = 1; ALUSrcA = 0; ALUSrcB = 0; rs1_data = 32'h1; rs2_data = 32'h2;
    for (int i = 0; i < 5; i++) begin
      cycle("flush_seq");
      tests_run++;
      if (bubble_cnt !== want[i] || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bubble_sat[%0d]: got c=%0d v=%b, want c=%0d v=0",
                 i, bubble_cnt, out_valid, want[i]);
      end
    end
    flush = 0;
  endtask

  task automatic test_rsvd_srcb();
    apply_reset();
    in_valid = 1; ForwardA = 0; ForwardB = 0; ALUSrcA = 0; ALUSrcB = 2'd3;
    imm = 12'hABC; rs2_data = 32'h0BAD_F00D;
    cycle("srcb_code3");
    tests_run++;
    if (UIMM) begin
      if (op_b !== 32'hABC0_0000 || sel_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL uimm_lit: got b=%h e=%b, want abc00000 0", op_b, sel_err);
      end
    end else begin
      if (op_b !== 32'h0BAD_F00D || sel_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL rsvd_b_lit: got b=%h e=%b, want 0badf00d 1", op_b, sel_err);
      end
    end
    ALUSrcB = 0; cycle("sel_err_sticky");
    cycle("sel_err_sticky2");
    // Reserved selects on an invalid instruction must not raise the flag.
    apply_reset();
    in_valid = 0; ForwardA = 2'd3; ALUSrcA = 2'd3; cycle("rsvd_invalid");
    in_valid = 1; ForwardA = 0; ALUSrcA = 2'd3; cycle("rsvd_a");
    ALUSrcA = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      in_valid = $urandom_range(0, 1);
      ForwardA = 2'($urandom_range(0, 3)); ForwardB = 2'($urandom_range(0, 3));
      ALUSrcA = 2'($urandom_range(0, 3));  ALUSrcB = 2'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; exmem_result = $urandom;
      memwb_result = $urandom; pc = $urandom; imm = 12'($urandom);
      cycle("random");
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    in_valid = 1; rs1_data = 32'h1111; rs2_data = 32'h2222; ALUSrcB = 2'd0;
    cycle("pre_reset_load");
    flush = 1; cycle("pre_reset_flush");
    flush = 0; cycle("pre_reset_load2");
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset_now");
    @(posedge clk);
    #1;
    check_zero("async_reset_held");
    m = '0;
    rst = 1'b0;
    cycle("first_capture");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_sext();
    test_stall_flush();
    test_bubble_sat();
    test_rsvd_srcb();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
